// File: rtl/acs_seq_ctrl.sv
// Nibble-serial wide adder sequencer driving one shared 4-bit acs slice.
// Operands are latched on start; one nibble is summed per clock, LSB first.
module acs_seq_ctrl #(
    parameter int NIBBLES = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [4*NIBBLES-1:0]   op_a,
    input  logic [4*NIBBLES-1:0]   op_b,
    input  logic                   cin,
    output logic                   busy,
    output logic                   done,
    output logic [4*NIBBLES-1:0]   sum,
    output logic                   cout,
    output logic [3:0]             acs_a,
    output logic [3:0]             acs_b,
    output logic                   acs_cin,
    input  logic [3:0]             acs_s,
    input  logic                   acs_c
);

    localparam int W  = 4 * NIBBLES;
    localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic [IW-1:0]   r_idx;
    logic [W-1:0]    r_a;
    logic [W-1:0]    r_b;
    logic [W-1:0]    r_sum;
    logic            r_carry;
    logic            r_cout;
    logic            w_accept;
    logic            w_last;
    logic [IW+1:0]   w_bit;

    assign w_bit    = {r_idx, 2'b00};
    assign w_last   = (r_idx == IW'(NIBBLES - 1));
    // DONE accepts a new request too, giving back-to-back operation
    assign w_accept = start && (r_state != RUN);
    assign sum      = r_sum;
    assign cout     = r_cout;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next  = r_state;
        busy    = 1'b0;
        done    = 1'b0;
        acs_a   = 4'd0;
        acs_b   = 4'd0;
        acs_cin = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (w_accept) w_next = RUN;
            end
            RUN: begin
                busy    = 1'b1;
                acs_a   = r_a[w_bit +: 4];
                acs_b   = r_b[w_bit +: 4];
                acs_cin = r_carry;
                if (w_last) w_next = DONE;
            end
            DONE: begin
                done   = 1'b1;
                w_next = w_accept ? RUN : IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx   <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_carry <= 1'b0;
            r_cout  <= 1'b0;
        end else if (w_accept) begin
            r_a     <= op_a;
            r_b     <= op_b;
            r_carry <= cin;
            r_idx   <= '0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
        end else if (r_state == RUN) begin
            r_sum[w_bit +: 4] <= acs_s;
            r_carry           <= acs_c;
            if (w_last) begin
                r_cout <= acs_c;
            end else begin
                r_idx <= r_idx + IW'(1);
            end
        end
    end

endmodule
